// File: rtl/g_truncated.sv
// Registered bit-field truncation: keeps the low N bits of In1 and zero-fills or sign-extends the rest.
// One cycle from an enabled capture to FinalOut/Valid; there is no stall path, so Enable is always accepted.
module g_truncated #(
   parameter int WIDTH = 32,
   parameter int LW    = 6
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic [WIDTH-1:0] In1,
   input  logic [31:0]      In2,
   input  logic             Enable,
   input  logic             SignExt,
   output logic [WIDTH-1:0] FinalOut,
   output logic             Valid
);

   logic             w_sat;
   logic [LW-2:0]    w_len;
   logic [LW-2:0]    w_top;
   logic [WIDTH-1:0] w_mask;
   logic             w_sign;
   logic [WIDTH-1:0] w_res;

   logic [WIDTH-1:0] r_out;
   logic             r_vld;

   // All 32 bits take part in the compare, so large requests saturate rather than wrap.
   assign w_sat = (In2 >= 32'(WIDTH));
   assign w_len = In2[LW-2:0];
   assign w_top = w_len - 1'b1;

   // When the length is below WIDTH the shift amount stays in range, so no overflow case exists.
   assign w_mask = w_sat ? {WIDTH{1'b1}} : ~({WIDTH{1'b1}} << w_len);

   assign w_sign = SignExt && !w_sat && (w_len != '0) && In1[w_top];
   assign w_res  = (In1 & w_mask) | (w_sign ? ~w_mask : '0);

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_out <= '0;
         r_vld <= 1'b0;
      end else begin
         r_vld <= Enable;
         if (Enable) begin
            r_out <= w_res;
         end
      end
   end

   assign FinalOut = r_out;
   assign Valid    = r_vld;

endmodule

// File: tb/tb_g_truncated.sv
// Directed and randomized checks of g_truncated against an arithmetic reference model.
module tb_g_truncated;

   logic        Clk;
   logic        Rst;
   logic [31:0] In1;
   logic [31:0] In2;
   logic        Enable;
   logic        SignExt;
   logic [31:0] FinalOut;
   logic        Valid;

   int vectors;
   int miscompares;

   logic [31:0] exp_out;
   logic        exp_vld;

   g_truncated #(.WIDTH(32), .LW(6)) dut (
      .Clk      (Clk),
      .Rst      (Rst),
      .In1      (In1),
      .In2      (In2),
      .Enable   (Enable),
      .SignExt  (SignExt),
      .FinalOut (FinalOut),
      .Valid    (Valid)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Reference: keep the low n bits, optionally replicate bit n-1 above them.
   function automatic logic [31:0] ref_trunc(input logic [31:0] a, input logic [31:0] n_req,
                                            input logic sx);
      longint unsigned n;
      longint unsigned keep;
      logic [31:0]     r;
      n    = (n_req > 32) ? 32 : longint'(n_req);
      keep = (64'd1 << n) - 64'd1;
      r    = a & keep[31:0];
      if (sx && n > 0 && n < 32 && a[n-1]) r = r | ~keep[31:0];
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive at the falling edge, then sample 1 time unit after the capture edge.
   task automatic step(input logic [31:0] a, input logic [31:0] n, input logic sx, input logic en);
      @(negedge Clk);
      In1 = a; In2 = n; SignExt = sx; Enable = en;
      @(posedge Clk);
      #1;
   endtask

   task automatic cap(input string tag, input logic [31:0] a, input logic [31:0] n,
                      input logic sx, input logic [31:0] exp);
      step(a, n, sx, 1'b1);
      check({tag, "_out"}, FinalOut, exp);
      check({tag, "_vld"}, {31'd0, Valid}, 32'd1);
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      Rst = 1'b1; Enable = 1'b1; In1 = $urandom; In2 = $urandom; SignExt = 1'b1;

      repeat (3) @(posedge Clk);
      #1;
      check("rst_out", FinalOut, 32'h0);
      check("rst_vld", {31'd0, Valid}, 32'd0);

      @(negedge Clk);
      Rst = 1'b0;
      cap("first", 32'hAA14498B, 32'd31, 1'b0, 32'h2A14498B);

      cap("sx8",  32'hAA14498B, 32'd8,  1'b1, 32'hFFFFFF8B);
      cap("sx16", 32'hAA14498B, 32'd16, 1'b1, 32'h0000498B);
      cap("sx31", 32'hAA14498B, 32'd31, 1'b1, 32'h2A14498B);
      cap("sx32", 32'hAA14498B, 32'd32, 1'b1, 32'hAA14498B);

      cap("zf0s", 32'hAA14498B, 32'd0,  1'b1, 32'h00000000);
      cap("zf8",  32'hAA14498B, 32'd8,  1'b0, 32'h0000008B);
      cap("zf0",  32'hAA14498B, 32'd0,  1'b0, 32'h00000000);
      cap("zf40", 32'hAA14498B, 32'd40, 1'b0, 32'hAA14498B);
      cap("zfbig", 32'hAA14498B, 32'h80000001, 1'b0, 32'hAA14498B);
      cap("sx33", 32'h00000080, 32'd33, 1'b1, 32'h00000080);

      cap("hold_cap", 32'hAA14498B, 32'd8, 1'b0, 32'h0000008B);
      for (int i = 0; i < 3; i++) begin
         step($urandom, $urandom_range(0, 40), 1'($urandom), 1'b0);
         check("hold_out", FinalOut, 32'h0000008B);
         check("hold_vld", {31'd0, Valid}, 32'd0);
      end

      cap("strm4",  32'hAA14498B, 32'd4,  1'b0, 32'h0000000B);
      cap("strm12", 32'hAA14498B, 32'd12, 1'b0, 32'h0000098B);
      cap("strm20", 32'hAA14498B, 32'd20, 1'b0, 32'h0004498B);

      // Inputs wiggling between edges must not reach the outputs.
      @(negedge Clk);
      Enable = 1'b0; In1 = 32'hFFFFFFFF; In2 = 32'd32;
      #2;
      In1 = 32'h12345678;
      #1;
      check("comb_out", FinalOut, 32'h0004498B);

      cap("ar_cap", 32'hAA14498B, 32'd16, 1'b1, 32'h0000498B);
      @(negedge Clk);
      Enable = 1'b1; In1 = 32'hAA14498B; In2 = 32'd32;
      #2;
      Rst = 1'b1;
      #1;
      check("ar_out", FinalOut, 32'h0);
      check("ar_vld", {31'd0, Valid}, 32'd0);
      @(posedge Clk);
      #1;
      check("ar_hold_out", FinalOut, 32'h0);
      check("ar_hold_vld", {31'd0, Valid}, 32'd0);
      @(negedge Clk);
      Rst = 1'b0;
      Enable = 1'b0;

      exp_out = 32'h0;
      exp_vld = 1'b0;
      for (int i = 0; i < 300; i++) begin
         logic [31:0] a, n;
         logic        sx, en;
         a  = $urandom;
         n  = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 40));
         sx = 1'($urandom);
         en = ($urandom_range(0, 3) != 0);
         step(a, n, sx, en);
         if (en) exp_out = ref_trunc(a, n, sx);
         exp_vld = en;
         check("rnd_out", FinalOut, exp_out);
         check("rnd_vld", {31'd0, Valid}, {31'd0, exp_vld});
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/g_truncated.md
Name: g_truncated

Overview:
- Registered bit-field truncation unit with a 32-bit datapath.
- Keeps the low N bits of In1, where N comes from In2.
- Clears the upper bits, or optionally sign-extends from bit N-1.
- Sits in the datapath as a single-cycle post-processing stage (width narrowing and immediate/field extraction) ahead of writeback.

Parameters:
- WIDTH, 32, datapath width of In1 and FinalOut; must be a power of two ≥ 8.
- LW, 6, width of the effective length field (log2(WIDTH)+1).

Ports:
- Clk  input  1  rising-edge clock
- Rst  input  1  asynchronous active-high reset
- In1  input  WIDTH  source operand to truncate
- In2  input  32  requested kept-bit count N (unsigned)
- Enable  input  1  capture strobe; new result computed and registered when high
- SignExt  input  1  0 = zero-fill upper bits, 1 = sign-extend from bit N-1
- FinalOut  output  WIDTH  registered truncated result
- Valid  output  1  high for exactly one cycle after each enabled capture

Behaviour:
- Reset: Rst high asynchronously forces FinalOut = 0 and Valid = 0, independent of Clk.
  - Both outputs stay 0 while Rst is held.
  - First capture is possible on the first rising edge after Rst deasserts.
- Effective length: Neff = min(In2, WIDTH).
  - Any In2 ≥ WIDTH, including In2[31:LW] nonzero, saturates to WIDTH.
  - Compare the full 32 bits; no modulo wrap.
- Mask: M = (Neff == WIDTH) ? all-ones : ((1 << Neff) - 1).
  - Build combinationally, without a WIDTH-bit shift overflow at Neff = WIDTH.
- Result R:
  - SignExt = 0: R = In1 & M.
  - SignExt = 1 and 0 < Neff < WIDTH: R = (In1 & M) | (In1[Neff-1] ? ~M : 0).
  - SignExt = 1 and Neff = WIDTH: R = In1.
  - Neff = 0: R = 0 regardless of SignExt.
- Latency: 1 cycle. On a rising edge with Enable = 1, FinalOut <= R and Valid <= 1.
- Enable = 0 at the edge: FinalOut holds its previous value and Valid <= 0.
- Back-to-back Enable: one result per cycle, Valid stays high continuously.
- Inputs are sampled only at the capture edge; changes between edges have no effect on outputs.
- Rst asserted mid-stream: the pending capture is discarded and outputs go to 0 immediately.
- No combinational path from any input to FinalOut or Valid.

Test Plan:
- Reset: Rst=1 with Enable=1 and arbitrary inputs -> FinalOut=0x00000000, Valid=0; release Rst, then In1=0xAA14498B, In2=31, SignExt=0, Enable=1 -> next edge FinalOut=0x2A14498B, Valid=1.
- Sign-extension and boundary: In1=0xAA14498B, SignExt=1:
  - In2=8 -> 0xFFFFFF8B
  - In2=16 -> 0x0000498B
  - In2=31 -> 0x2A14498B
  - In2=32 -> 0xAA14498B
- Zero-fill and saturation: In1=0xAA14498B, SignExt=0:
  - In2=8 -> 0x0000008B
  - In2=0 -> 0x00000000 (also with SignExt=1)
  - In2=40 -> 0xAA14498B
  - In2=0x80000001 -> 0xAA14498B
- Hold: capture 0x0000008B, then Enable=0 for 3 cycles while In1/In2 change -> FinalOut stays 0x0000008B, Valid=0 on each of those edges.
- Streaming: Enable=1 for consecutive edges with In2=4, 12, 20 (In1=0xAA14498B, SignExt=0) -> FinalOut 0x0000000B, 0x0000098B, 0x0004498B on successive cycles, Valid held 1.
- Asynchronous reset mid-operation: assert Rst between edges after a capture -> FinalOut and Valid drop to 0 before the next edge and remain 0 until Rst clears.
